uart_matrix_printer: RTL and testbench

Parametrised successor to the team's UART table dumper. On a start pulse it snapshots a ROWS x COLS table of VAL_W-bit cells plus a total count. It then streams them as ASCII through the byte-wide UART TX handshake, using multi-digit decimal with leading-zero suppression and optional CR/LF row breaks. It sits between the matching/recording core and the shared uart_tx, and adds abort and byte-count outputs for debug.

---
 rtl/uart_matrix_printer_if.sv | 30 +++
 rtl/uart_matrix_printer.sv | 170 +++++++++++++++++
 tb/tb_uart_matrix_printer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_matrix_printer_if.sv
// Request/status and byte-wide UART TX handshake for uart_matrix_printer.
// master = client side (start/abort/data/tx busy), slave = the printer itself.
interface uart_matrix_printer_if #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int VAL_W = 2,
    parameter int CNT_W = 8
);
    logic                          start;
    logic                          abort;
    logic [ROWS*COLS*VAL_W-1:0]    info_table;
    logic [CNT_W-1:0]              cnt;
    logic                          uart_tx_busy;
    logic                          uart_tx_en;
    logic [7:0]                    uart_tx_data;
    logic                          busy;
    logic                          done;
    logic                          aborted;
    logic [15:0]                   byte_cnt;

    modport master (
        output start, abort, info_table, cnt, uart_tx_busy,
        input  uart_tx_en, uart_tx_data, busy, done, aborted, byte_cnt
    );

    modport slave (
        input  start, abort, info_table, cnt, uart_tx_busy,
        output uart_tx_en, uart_tx_data, busy, done, aborted, byte_cnt
    );
endinterface

// File: rtl/uart_matrix_printer.sv
// Snapshots a ROWS x COLS table plus a count and streams it as ASCII decimal
// ("cnt\r\n" then "r*c*val" cells) through a one-byte-per-strobe UART TX handshake.
module uart_matrix_printer #(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int VAL_W     = 2,
    parameter int CNT_W     = 8,
    parameter int LINE_MODE = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    uart_matrix_printer_if.slave bus
);
    localparam int TW = ROWS * COLS * VAL_W;

    typedef enum logic [3:0] {
        IDLE, HDR_PREP, HDR_DIG, HDR_CR, HDR_LF, CELL_PREP, ROW_CH, STAR1,
        COL_CH, STAR2, VAL_DIG, SEP, SEP_LF, WAIT, DONE
    } state_t;

    state_t            state, ret_state;
    logic [TW-1:0]     sh_table;
    logic [CNT_W-1:0]  sh_cnt;
    logic [3:0]        row, col;
    logic [3:0]        dig2, dig1, dig0;
    logic [1:0]        dig_idx;
    logic              tx_en, busy_q, done_q, aborted_q;
    logic [7:0]        tx_data;
    logic [15:0]       byte_cnt_q;

    int                cell_base;
    logic [7:0]        prep_val;
    logic [3:0]        p2, p1, p0, cur_dig;
    logic              row_end, last_cell, emit_state;
    logic [7:0]        emit_byte;
    state_t            emit_next;

    always_comb begin
        cell_base = ((int'(row) - 1) * COLS + int'(col) - 1) * VAL_W;
        prep_val  = (state == HDR_PREP) ? 8'(sh_cnt) : 8'(sh_table[cell_base +: VAL_W]);
        p2 = 4'(prep_val / 8'd100);
        p1 = 4'((prep_val / 8'd10) % 8'd10);
        p0 = 4'(prep_val % 8'd10);
        case (dig_idx)
            2'd2:    cur_dig = dig2;
            2'd1:    cur_dig = dig1;
            default: cur_dig = dig0;
        endcase
        row_end   = (col == 4'(COLS));
        last_cell = row_end && (row == 4'(ROWS));

        emit_state = 1'b1;
        emit_byte  = 8'h00;
        emit_next  = IDLE;
        case (state)
            HDR_DIG: begin
                emit_byte = 8'h30 + {4'h0, cur_dig};
                emit_next = (dig_idx == 2'd0) ? HDR_CR : HDR_DIG;
            end
            HDR_CR:  begin emit_byte = 8'h0D; emit_next = HDR_LF;    end
            HDR_LF:  begin emit_byte = 8'h0A; emit_next = CELL_PREP; end
            ROW_CH:  begin emit_byte = 8'h30 + {4'h0, row}; emit_next = STAR1;  end
            STAR1:   begin emit_byte = 8'h2A; emit_next = COL_CH;    end
            COL_CH:  begin emit_byte = 8'h30 + {4'h0, col}; emit_next = STAR2;  end
            STAR2:   begin emit_byte = 8'h2A; emit_next = VAL_DIG;   end
            VAL_DIG: begin
                emit_byte = 8'h30 + {4'h0, cur_dig};
                emit_next = (dig_idx == 2'd0) ? SEP : VAL_DIG;
            end
            SEP: begin
                if (LINE_MODE != 0 && row_end) begin
                    emit_byte = 8'h0D;
                    emit_next = SEP_LF;
                end else begin
                    emit_byte = 8'h20;
                    emit_next = last_cell ? DONE : CELL_PREP;
                end
            end
            SEP_LF:  begin emit_byte = 8'h0A; emit_next = last_cell ? DONE : CELL_PREP; end
            default: emit_state = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ret_state  <= IDLE;
            sh_table   <= '0;
            sh_cnt     <= '0;
            row        <= 4'd1;
            col        <= 4'd1;
            dig2       <= 4'd0;
            dig1       <= 4'd0;
            dig0       <= 4'd0;
            dig_idx    <= 2'd0;
            tx_en      <= 1'b0;
            tx_data    <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            byte_cnt_q <= 16'd0;
        end else begin
            tx_en     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (bus.abort && state != IDLE && state != DONE) begin
                state     <= IDLE;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
            end else if (emit_state) begin
                // A byte is only offered while the transmitter is free.
                if (!bus.uart_tx_busy) begin
                    tx_en      <= 1'b1;
                    tx_data    <= emit_byte;
                    byte_cnt_q <= byte_cnt_q + 16'd1;
                    ret_state  <= emit_next;
                    state      <= WAIT;
                    if (state == HDR_DIG || state == VAL_DIG)
                        dig_idx <= dig_idx - 2'd1;
                    if ((state == SEP || state == SEP_LF) && emit_next != SEP_LF) begin
                        if (row_end) begin
                            col <= 4'd1;
                            row <= row + 4'd1;
                        end else begin
                            col <= col + 4'd1;
                        end
                    end
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            sh_table   <= bus.info_table;
                            sh_cnt     <= bus.cnt;
                            byte_cnt_q <= 16'd0;
                            busy_q     <= 1'b1;
                            row        <= 4'd1;
                            col        <= 4'd1;
                            state      <= HDR_PREP;
                        end
                    end
                    HDR_PREP, CELL_PREP: begin
                        dig2    <= p2;
                        dig1    <= p1;
                        dig0    <= p0;
                        dig_idx <= (p2 != 4'd0) ? 2'd2 : (p1 != 4'd0) ? 2'd1 : 2'd0;
                        state   <= (state == HDR_PREP) ? HDR_DIG : ROW_CH;
                    end
                    WAIT: begin
                        if (!bus.uart_tx_busy) begin
                            state <= ret_state;
                            if (ret_state == DONE) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.uart_tx_en   = tx_en;
    assign bus.uart_tx_data = tx_data;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.byte_cnt     = byte_cnt_q;
endmodule

// File: tb/tb_uart_matrix_printer.sv
// Bench for uart_matrix_printer: three configurations captured byte-by-byte and
// compared against hand-written strings and a string-building reference.
module tb_uart_matrix_printer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_matrix_printer_if #(.ROWS(5), .COLS(5), .VAL_W(2), .CNT_W(8)) if0 ();
    uart_matrix_printer_if #(.ROWS(5), .COLS(5), .VAL_W(2), .CNT_W(8)) if1 ();
    uart_matrix_printer_if #(.ROWS(2), .COLS(2), .VAL_W(8), .CNT_W(8)) if2 ();

    uart_matrix_printer #(.ROWS(5), .COLS(5), .VAL_W(2), .CNT_W(8), .LINE_MODE(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    uart_matrix_printer #(.ROWS(5), .COLS(5), .VAL_W(2), .CNT_W(8), .LINE_MODE(0))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    uart_matrix_printer #(.ROWS(2), .COLS(2), .VAL_W(8), .CNT_W(8), .LINE_MODE(1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    localparam string CRLF = "\015\012";

    int n_vec = 0;
    int n_fail = 0;
    logic busy0 = 1'b0;
    int hold_max = 0;
    int hold_rem = 0;
    int viol0 = 0;
    int abort_n0 = 0;
    int done_n0 = 0, done_n1 = 0, done_n2 = 0;
    logic [7:0] cap0[$], cap1[$], cap2[$];

    assign if0.uart_tx_busy = busy0;
    assign if1.uart_tx_busy = 1'b0;
    assign if2.uart_tx_busy = 1'b0;

    always @(negedge clk) begin
        if (if0.uart_tx_en) cap0.push_back(if0.uart_tx_data);
        if (if1.uart_tx_en) cap1.push_back(if1.uart_tx_data);
        if (if2.uart_tx_en) cap2.push_back(if2.uart_tx_data);
        if (if0.done) done_n0++;
        if (if1.done) done_n1++;
        if (if2.done) done_n2++;
        if (if0.aborted) abort_n0++;
    end

    // UART model for u0: busy rises with each strobe and holds a random number of cycles.
    always @(negedge clk) begin
        if (if0.uart_tx_en && busy0) viol0++;
        if (hold_rem > 0) begin
            hold_rem--;
            if (hold_rem == 0) busy0 = 1'b0;
        end
        if (if0.uart_tx_en && hold_max > 0) begin
            busy0 = 1'b1;
            hold_rem = $urandom_range(1, hold_max);
        end
    end

    function automatic string esc(input string s);
        string r = "";
        for (int i = 0; i < s.len() && i < 200; i++) begin
            if (s[i] == 8'h0D) r = {r, "\\r"};
            else if (s[i] == 8'h0A) r = {r, "\\n"};
            else r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    function automatic string num(input longint v);
        return $sformatf("%0d", v);
    endfunction

    function automatic string q2s(input logic [7:0] q[$], input int from);
        string r = "";
        for (int i = from; i < q.size(); i++) r = $sformatf("%s%c", r, q[i]);
        return r;
    endfunction

    function automatic string tail(input string s, input int n);
        return (s.len() >= n) ? s.substr(s.len() - n, s.len() - 1) : "";
    endfunction

    function automatic string model(input int rows, input int cols, input int vals[],
                                    input int c, input bit lm);
        string s;
        s = {$sformatf("%0d", c), CRLF};
        for (int r = 1; r <= rows; r++) begin
            for (int k = 1; k <= cols; k++) begin
                s = {s, $sformatf("%0d*%0d*%0d", r, k, vals[(r-1)*cols + k-1])};
                if (lm && k == cols) s = {s, CRLF};
                else s = {s, " "};
            end
        end
        return s;
    endfunction

    task automatic check_eq(input string tag, input string got, input string exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", tag, esc(got), esc(exp));
        end
    endtask

    int v5[];
    int v2[];
    string exp_lm1, exp_lm0, exp_small, got;
    int b0, b1, b2, d0, d1, d2, a0, vi;

    task automatic load_default();
        if0.info_table = '0;
        if0.info_table[1:0] = 2'd3;
        if0.cnt = 8'd7;
    endtask

    initial begin
        v5 = new[25];
        v5[0] = 3;
        v2 = '{0, 9, 10, 255};
        exp_lm1 = model(5, 5, v5, 7, 1'b1);
        exp_lm0 = model(5, 5, v5, 7, 1'b0);
        exp_small = {"125", CRLF, "1*1*0 1*2*9", CRLF, "2*1*10 2*2*255", CRLF};

        if0.start = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;
        if2.start = 1'b0; if2.abort = 1'b0;
        load_default();
        if1.info_table = '0; if1.info_table[1:0] = 2'd3; if1.cnt = 8'd7;
        if2.info_table = {8'd255, 8'd10, 8'd9, 8'd0}; if2.cnt = 8'd125;

        repeat (3) @(negedge clk);
        check_eq("rst_tx_en",   num(if0.uart_tx_en),   "0");
        check_eq("rst_tx_data", num(if0.uart_tx_data), "0");
        check_eq("rst_busy",    num(if0.busy),         "0");
        check_eq("rst_done",    num(if0.done),         "0");
        check_eq("rst_aborted", num(if0.aborted),      "0");
        check_eq("rst_byte_cnt", num(if0.byte_cnt),    "0");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All three start together; inputs are trashed right after the snapshot edge.
        b0 = cap0.size(); b1 = cap1.size(); b2 = cap2.size();
        d0 = done_n0; d1 = done_n1; d2 = done_n2;
        if0.start = 1'b1; if1.start = 1'b1; if2.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        check_eq("start_busy", num(if0.busy), "1");
        if0.info_table = '1; if0.cnt = 8'hAA;
        if1.info_table = '1; if1.cnt = 8'hAA;
        if2.info_table = '1; if2.cnt = 8'hAA;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_n0 > d0 && done_n1 > d1 && done_n2 > d2) break;
        end
        repeat (10) @(negedge clk);
        got = q2s(cap0, b0);
        check_eq("lm1_prefix",   got.substr(0, 13), {"7", CRLF, "1*1*3 1*2*0"});
        check_eq("lm1_row1_end", got.substr(27, 33), {"1*5*0", CRLF});
        check_eq("lm1_suffix",   tail(got, 7), {"5*5*0", CRLF});
        check_eq("lm1_stream",   got, exp_lm1);
        check_eq("lm1_byte_cnt", num(if0.byte_cnt), "158");
        check_eq("lm1_done_n",   num(done_n0 - d0), "1");
        check_eq("lm1_idle",     num(if0.busy), "0");
        got = q2s(cap1, b1);
        check_eq("lm0_row1_end", got.substr(27, 37), "1*5*0 2*1*0");
        check_eq("lm0_suffix",   tail(got, 6), "5*5*0 ");
        check_eq("lm0_stream",   got, exp_lm0);
        check_eq("lm0_byte_cnt", num(if1.byte_cnt), "153");
        check_eq("lm0_done_n",   num(done_n1 - d1), "1");
        got = q2s(cap2, b2);
        check_eq("w8_stream",    got, exp_small);
        check_eq("w8_byte_cnt",  num(if2.byte_cnt), "34");
        check_eq("w8_done_n",    num(done_n2 - d2), "1");

        // Random transmitter back-pressure on u0.
        load_default();
        hold_max = 20;
        b0 = cap0.size(); d0 = done_n0; vi = viol0;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (done_n0 > d0) break;
        end
        hold_max = 0;
        repeat (25) @(negedge clk);
        check_eq("bp_stream",   q2s(cap0, b0), exp_lm1);
        check_eq("bp_violations", num(viol0 - vi), "0");
        check_eq("bp_done_n",   num(done_n0 - d0), "1");
        check_eq("bp_byte_cnt", num(if0.byte_cnt), "158");

        // Abort right after the 20th strobe.
        b0 = cap0.size(); d0 = done_n0; a0 = abort_n0;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (cap0.size() - b0 >= 20) break;
        end
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("ab_strobes",  num(cap0.size() - b0), "20");
        check_eq("ab_aborted_n", num(abort_n0 - a0), "1");
        check_eq("ab_no_done",  num(done_n0 - d0), "0");
        check_eq("ab_byte_cnt", num(if0.byte_cnt), "20");
        check_eq("ab_busy",     num(if0.busy), "0");
        check_eq("ab_prefix",   q2s(cap0, b0), exp_lm1.substr(0, 19));

        // Abort alone in IDLE does nothing.
        a0 = abort_n0;
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        @(negedge clk);
        check_eq("idle_abort_n",    num(abort_n0 - a0), "0");
        check_eq("idle_abort_busy", num(if0.busy), "0");

        // start+abort together: start wins; a later start mid-dump is ignored.
        b0 = cap0.size(); d0 = done_n0; a0 = abort_n0;
        if0.start = 1'b1; if0.abort = 1'b1;
        @(negedge clk);
        if0.start = 1'b0; if0.abort = 1'b0;
        check_eq("sa_busy",     num(if0.busy), "1");
        check_eq("sa_byte_cnt", num(if0.byte_cnt), "0");
        repeat (50) @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_n0 > d0) break;
        end
        repeat (20) @(negedge clk);
        check_eq("re_stream",    q2s(cap0, b0), exp_lm1);
        check_eq("re_byte_cnt",  num(if0.byte_cnt), "158");
        check_eq("re_done_n",    num(done_n0 - d0), "1");
        check_eq("re_aborted_n", num(abort_n0 - a0), "0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
